// File: rtl/light_seq_pkg.sv
// Shared types and helpers for the light sequencer: light state encoding and
// the randomised phase-length formula.
package light_seq_pkg;

    typedef enum logic [1:0] {
        L_IDLE  = 2'd0,
        L_GREEN = 2'd1,
        L_WARN  = 2'd2,
        L_RED   = 2'd3
    } light_state_t;

    localparam int LEN_W = 32;

    // Phase length in ticks; callers truncate to their own counter width.
    function automatic logic [LEN_W-1:0] phase_len(
        input logic [LEN_W-1:0] min_ticks,
        input logic [3:0]       lfsr,
        input logic [LEN_W-1:0] step_ticks
    );
        return min_ticks + ({28'd0, lfsr} * step_ticks);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter producing a one-cycle tick on the last
// count; a synchronous clear restarts the count from zero.
module tick_prescaler #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/light_sequencer.sv
// Green/warn/red light sequencer with LFSR-randomised phase lengths.
// Define LIGHT_SEQ_WARN_EN to insert the fixed-length WARN phase before RED.
module light_sequencer
    import light_seq_pkg::*;
#(
    parameter int TICK_DIV        = 500000,
    parameter int GREEN_MIN_TICKS = 100,
    parameter int RED_MIN_TICKS   = 100,
    parameter int STEP_TICKS      = 20,
    parameter int WARN_TICKS      = 50,
    parameter int DUR_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] lfsr_in,
    output logic       red_light,
    output logic       green_light,
    output logic       warn_light,
    output logic       phase_start,
    output logic [1:0] light_state
);

    localparam longint MAX_MIN   = (GREEN_MIN_TICKS > RED_MIN_TICKS) ? GREEN_MIN_TICKS : RED_MIN_TICKS;
    localparam longint MAX_LEN   = MAX_MIN + 15 * longint'(STEP_TICKS);
    localparam longint DUR_LIMIT = longint'(1) << DUR_W;

    if (MAX_LEN >= DUR_LIMIT || longint'(WARN_TICKS) >= DUR_LIMIT) begin : g_dur_w_too_narrow
        $error("light_sequencer: DUR_W cannot hold the longest phase");
    end

    light_state_t     state, state_d;
    logic [DUR_W-1:0] remaining, remaining_d;
    logic [DUR_W-1:0] green_len, red_len;
    logic             start_d;
    logic             tick;
    logic             expiry;
    logic             presc_clear;

    assign green_len = DUR_W'(phase_len(LEN_W'(GREEN_MIN_TICKS), lfsr_in, LEN_W'(STEP_TICKS)));
    assign red_len   = DUR_W'(phase_len(LEN_W'(RED_MIN_TICKS), lfsr_in, LEN_W'(STEP_TICKS)));
    assign expiry    = tick && (remaining == DUR_W'(1));

    // Prescaler restarts on every phase load and stays parked while idle.
    assign presc_clear = start_d || (state_d == L_IDLE);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(presc_clear),
        .tick (tick)
    );

    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        start_d     = 1'b0;
        if (!enable) begin
            state_d     = L_IDLE;
            remaining_d = '0;
        end else begin
            case (state)
                L_IDLE: begin
                    state_d     = L_GREEN;
                    remaining_d = green_len;
                    start_d     = 1'b1;
                end
                L_GREEN: begin
                    if (expiry) begin
`ifdef LIGHT_SEQ_WARN_EN
                        state_d     = L_WARN;
                        remaining_d = DUR_W'(WARN_TICKS);
`else
                        state_d     = L_RED;
                        remaining_d = red_len;
`endif
                        start_d     = 1'b1;
                    end else if (tick) begin
                        remaining_d = remaining - 1'b1;
                    end
                end
`ifdef LIGHT_SEQ_WARN_EN
                L_WARN: begin
                    if (expiry) begin
                        state_d     = L_RED;
                        remaining_d = red_len;
                        start_d     = 1'b1;
                    end else if (tick) begin
                        remaining_d = remaining - 1'b1;
                    end
                end
`endif
                L_RED: begin
                    if (expiry) begin
                        state_d     = L_GREEN;
                        remaining_d = green_len;
                        start_d     = 1'b1;
                    end else if (tick) begin
                        remaining_d = remaining - 1'b1;
                    end
                end
                default: begin
                    state_d     = L_IDLE;
                    remaining_d = '0;
                end
            endcase
        end
    end

    // Lamps are registered from the next state so reset drops them at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= L_IDLE;
            remaining   <= '0;
            red_light   <= 1'b0;
            green_light <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            state       <= state_d;
            remaining   <= remaining_d;
            red_light   <= (state_d == L_RED);
            green_light <= (state_d == L_GREEN);
            phase_start <= start_d;
        end
    end

`ifdef LIGHT_SEQ_WARN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warn_light <= 1'b0;
        end else begin
            warn_light <= (state_d == L_WARN);
        end
    end
`else
    assign warn_light = 1'b0;
`endif

    assign light_state = state;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: a phase-level model predicts each
// cycle's lamps and phase_start; a negedge monitor compares against the DUT.
module tb_light_sequencer;

    localparam int TD = 2;
    localparam int GM = 3;
    localparam int RM = 2;
    localparam int ST = 1;
    localparam int WT = 2;
`ifdef LIGHT_SEQ_WARN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] lfsr_in = 4'd0;
    logic       red_light, green_light, warn_light, phase_start;
    logic [1:0] light_state;

    light_sequencer #(
        .TICK_DIV       (TD),
        .GREEN_MIN_TICKS(GM),
        .RED_MIN_TICKS  (RM),
        .STEP_TICKS     (ST),
        .WARN_TICKS     (WT),
        .DUR_W          (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .lfsr_in    (lfsr_in),
        .red_light  (red_light),
        .green_light(green_light),
        .warn_light (warn_light),
        .phase_start(phase_start),
        .light_state(light_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       ps;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Model: 0 idle, 1 green, 2 warn, 3 red; m_left counts clk cycles left.
    int   m_phase = 0;
    int   m_left = 0;
    logic m_start = 1'b0;

    function automatic int dur_cycles(input int min_t, input int lf);
        return (min_t + lf * ST) * TD;
    endfunction

    task automatic model_step(input logic en, input logic [3:0] lf);
        m_start = 1'b0;
        if (!reset || !en) begin
            m_phase = 0;
            m_left  = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_left  = dur_cycles(GM, int'(lf));
            m_start = 1'b1;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_start = 1'b1;
                if (m_phase == 1 && WARN_EN) begin
                    m_phase = 2;
                    m_left  = WT * TD;
                end else if (m_phase == 1 || m_phase == 2) begin
                    m_phase = 3;
                    m_left  = dur_cycles(RM, int'(lf));
                end else begin
                    m_phase = 1;
                    m_left  = dur_cycles(GM, int'(lf));
                end
            end
        end
    endtask

    task automatic cycle(input logic en, input logic [3:0] lf);
        exp_t e;
        enable  = en;
        lfsr_in = lf;
        model_step(en, lf);
        e.st = 2'(m_phase);
        e.ps = m_start;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic run_until_red(input int left_target);
        int n;
        n = 0;
        while (!(m_phase == 3 && m_left == left_target) && n < 200) begin
            cycle(1'b1, 4'd0);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL reach_red: waited %0d cycles, required RED with %0d cycles left", n, left_target);
        end
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({red_light, green_light, warn_light, phase_start, light_state} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset: r/g/w/ps/st=%b%b%b%b/%0d required 0000/0",
                     red_light, green_light, warn_light, phase_start, light_state);
        end
        m_phase = 0;
        m_left  = 0;
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [5:0] act, req;
        cyc++;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {red_light, green_light, warn_light, phase_start, light_state};
            req = {e.st == 2'd3, e.st == 2'd1, e.st == 2'd2, e.ps, e.st};
            checks++;
            if (act !== req) begin
                failures++;
                $display("FAIL cycle_check cyc=%0d: r/g/w/ps/st=%b%b%b%b/%0d required %b%b%b%b/%0d",
                         cyc, act[5], act[4], act[3], act[2], act[1:0],
                         req[5], req[4], req[3], req[2], req[1:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held, then idle with enable low.
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'($urandom));

        // Steady sequence with lfsr_in = 0.
        for (int i = 0; i < 32; i++) cycle(1'b1, 4'd0);

        // Long green from lfsr 15, later lfsr changes must be ignored.
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'd0);
        cycle(1'b1, 4'd15);
        for (int i = 0; i < 50; i++) cycle(1'b1, 4'd0);

        // Drop enable three cycles into RED, then re-enable.
        run_until_red(2);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'($urandom));
        for (int i = 0; i < 14; i++) cycle(1'b1, 4'd0);

        // Asynchronous reset in the middle of RED.
        run_until_red(3);
        async_reset_check();
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'd0);

        // Randomised lfsr and enable drops.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                int gap;
                gap = int'($urandom_range(1, 6));
                for (int j = 0; j < gap; j++) cycle(1'b0, 4'($urandom));
            end else begin
                cycle(1'b1, 4'($urandom));
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
- Upstream stage of game_controller. Generates the red_light signal that game_controller uses to decide disqualification.
- Also drives green and warning lamp outputs for the VGA/LED display path.
- Phase lengths are randomised per phase from a 4-bit LFSR value (lfsr_in). A fixed-length warning phase precedes every red phase.
- Runs only while game_controller reports game_active. Otherwise it sits idle with all lights off.

Parameters:
- TICK_DIV, 500000, clk cycles per timing tick (10 ms at 50 MHz).
- GREEN_MIN_TICKS, 100, green length when lfsr_in=0.
- RED_MIN_TICKS, 100, red length when lfsr_in=0.
- STEP_TICKS, 20, extra ticks per LFSR unit (phase = MIN + lfsr_in*STEP_TICKS).
- WARN_TICKS, 50, fixed warning length.
- DUR_W, 16, width of the phase-remaining counter. Must hold max(GREEN_MIN_TICKS,RED_MIN_TICKS)+15*STEP_TICKS; elaboration-time assertion.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (0 = reset)
- enable  in  1  connect to game_controller game_active
- lfsr_in  in  4  pseudo-random value, sampled only on phase load
- red_light  out  1  1 only in RED; feeds game_controller red_light
- green_light  out  1  1 only in GREEN
- warn_light  out  1  1 only in WARN
- phase_start  out  1  one-cycle pulse on entry to GREEN, WARN or RED
- light_state  out  2  encoded light_state_t, for debug/display

Behaviour:
- Reset (async, reset=0): state=L_IDLE; prescaler=0; remaining=0; all outputs 0. Outputs are registered.
- L_IDLE: all lights 0.
  - enable=1 at a clk edge → L_GREEN at that edge.
  - Same edge loads remaining=GREEN_MIN_TICKS+lfsr_in*STEP_TICKS, clears the prescaler, and sets phase_start=1 for one cycle.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 when prescaler==TICK_DIV-1. Cleared on every phase load.
- Phase countdown:
  - On tick, remaining decrements.
  - On tick with remaining==1, the next phase loads at that same edge.
  - Every phase therefore lasts exactly duration*TICK_DIV cycles.
- Transitions:
  - GREEN → WARN: remaining=WARN_TICKS.
  - WARN → RED: remaining=RED_MIN_TICKS+lfsr_in*STEP_TICKS.
  - RED → GREEN: green formula as above.
  - Each transition pulses phase_start for one cycle.
- lfsr_in is sampled only on the load edge. Changes mid-phase have no effect.
- enable=0 in any state → L_IDLE at the next edge: lights 0, prescaler and remaining cleared, no phase_start.
- enable re-asserted → always restarts at GREEN with a fresh duration. It never resumes the old phase.
- enable=0 on the same edge as a phase expiry: IDLE wins.
- Mutual exclusion: at most one of red/green/warn is 1 in any cycle.
- Arithmetic: lfsr_in*STEP_TICKS is computed at DUR_W width, unsigned. Overflow is prevented by the elaboration assertion.
- Mid-operation reset: returns to IDLE asynchronously. red_light drops immediately, with no spurious disqualification pulse.

Optional Feature:
- Macro: LIGHT_SEQ_WARN_EN.
- Defined: WARN phase exists as described above.
- Undefined:
  - WARN state and WARN_TICKS logic are removed.
  - GREEN → RED directly, with the red duration loaded on the green expiry edge.
  - warn_light is tied to 0.
  - The light_state encoding is unchanged (L_WARN is never produced).

Decomposition:
- Package light_seq_pkg:
  - typedef enum logic[1:0] light_state_t {L_IDLE=0, L_GREEN=1, L_WARN=2, L_RED=3}.
  - Helper function phase_len(min, lfsr, step).
- Sub-module tick_prescaler:
  - Parameter TICK_DIV; inputs clk, reset, clear; output tick.
  - Reused elsewhere for round-end delays.

Test Plan (override TICK_DIV=2, GREEN_MIN_TICKS=3, RED_MIN_TICKS=2, STEP_TICKS=1, WARN_TICKS=2):
- Reset then hold enable=0 for 20 cycles → all lights 0, light_state=0, phase_start never 1.
- enable=1, lfsr_in=0 constant:
  - green_light=1 for exactly 6 cycles, then warn_light=1 for 4 cycles, then red_light=1 for 4 cycles, then green again.
  - phase_start pulses at each of the 3 boundaries.
- lfsr_in=15 at green load, then changed to 0 mid-phase → green lasts 36 cycles. lfsr_in=0 at the warn→red edge → red lasts 4 cycles.
- enable dropped 3 cycles into RED → red_light=0 at the next edge. Re-enable after 5 cycles → green restarts with the full 6 cycles for lfsr_in=0.
- reset asserted asynchronously mid-RED (between edges) → red_light=0 immediately, without waiting for a clk edge. After release with enable=1 → GREEN on the first edge.
- Compile without LIGHT_SEQ_WARN_EN, lfsr_in=0 → green 6 cycles then red 4 cycles; warn_light constantly 0.
